echo_restore: RTL and testbench
===============================

// Module: echo_restore
// PURPOSE
//  Inverse (feed-forward) comb for the multi-echo feedback processor.
//  The feedback path computes y = x - (delayed_y >>> 1); this block computes
//  y = x + (x[n-DELAY] >>> 1), so a cascade restores the original signal.
//  Sits between ADC sample capture and DAC output. Its delay line is an
//  inferred circular RAM, not a FIFO IP.
// PARAMETERS
//  DELAY       8192    echo delay in samples; 2 <= DELAY <= 2**ADDR_W
//  ADDR_W      13      RAM address width
//  ADC_OFFSET  10'h181 subtracted from data_in to form 2's-complement x
//  DAC_OFFSET  10'h200 added to y to form data_out
// PORTS
//  sysclk      in   1   system clock; all logic on posedge
//  rst         in   1   reset; synchronous, active-high
//  data_in     in   10  offset-binary ADC sample
//  data_valid  in   1   sample strobe; level, may stay high for many cycles
//  data_out    out  10  offset-binary DAC sample, registered
//  out_valid   out  1   one-cycle pulse when data_out is updated
//  primed      out  1   high once the delay line holds DELAY real samples
// BEHAVIOUR
//  - Reset is synchronous, active-high. On reset: data_out=DAC_OFFSET,
//    out_valid=0, primed=0, wr_ptr=0, fill_cnt=0, state=FILL, pipeline flushed.
//    The edge register dv_r resets to 1, so a data_valid level held through
//    reset produces no tick. RAM contents are not cleared.
//  - tick = data_valid & ~dv_r (combinational). dv_r <= data_valid every cycle.
//    One sample is taken per rising edge of data_valid.
//  - Tick cycle T:
//    x = data_in - ADC_OFFSET, mod 1024.
//    Register x_r.
//    Issue a RAM read and a RAM write of x to address wr_ptr. The read returns
//    the old data (read-before-write).
//    wr_ptr <= (wr_ptr==DELAY-1) ? 0 : wr_ptr+1.
//  - T+1: d = RAM output, or 0 if the sample was taken in state FILL.
//    sum = sext11(x_r) + sext11(d>>>1) (arithmetic shift).
//    Saturate sum to [-512, +511].
//    data_out <= sat + DAC_OFFSET (mod 1024).
//    out_valid <= 1.
//  - T+2: out_valid is high for exactly one cycle. Fixed latency is 2 cycles
//    from tick to new data_out. data_out holds its value between samples.
//  - FSM states:
//    FILL: fill_cnt increments per tick. When tick occurs with
//      fill_cnt==DELAY-1, next state is RUN.
//    RUN: fill_cnt is frozen; primed=1. RUN exits only on rst.
//    The sample with tick index k (from 0) uses d = sample k-DELAY when
//    k >= DELAY, and d = 0 otherwise.
//  - Back-to-back ticks every 2 cycles are supported; pipeline stages hold
//    independent copies of their data.
//  - rst asserted mid-operation drops in-flight samples; out_valid is not
//    pulsed for them.
//  - Cascade identity: echo processor -> echo_restore with ADC_OFFSET=10'h200
//    gives data_out = original x + 10'h200, exact barring saturation.
// TESTING  (DELAY=4, ADDR_W=2 unless noted)
//  1 Reset: rst high 3 cycles with data_valid=1 -> data_out=0x200, out_valid=0,
//    primed=0; releasing rst with data_valid still high -> no out_valid.
//  2 Impulse: ticks on 0x181,0x1C1,0x181x5 -> outputs 0x200,0x240,0x200,
//    0x200,0x200,0x220,0x200; primed rises after the 4th tick.
//  3 Fill masking: preload RAM with 0x155 via backdoor; first 4 samples of
//    x=0 -> all outputs 0x200 exactly.
//  4 Saturation: data_in=0x380 (x=+511) steady; post-prime out 0x3FF.
//    data_in=0x381 (x=-512) -> 0x000 both before and after prime.
//  5 Strobe: data_valid high 10 cycles -> one out_valid, 2 cycles after rise;
//    ticks 2 cycles apart -> every sample output in order.
//  6 Mid-run reset plus cascade: after RUN, pulse rst -> primed=0, next 4
//    outputs use d=0. Drive a random 200-sample stream through the echo
//    processor model then this block (DELAY=8) -> output equals input
//    + 0x200 on every sample.

Source files
------------

// File: rtl/echo_restore.sv
// echo_restore: feed-forward comb y = x + (x[n-DELAY] >>> 1) that undoes the multi-echo feedback processor.
// Offset-binary samples in and out, one sample per rising edge of data_valid, fixed 2-cycle latency.
module echo_restore #(
    parameter int DELAY = 8192,
    parameter int ADDR_W = 13,
    parameter logic [9:0] ADC_OFFSET = 10'h181,
    parameter logic [9:0] DAC_OFFSET = 10'h200
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [9:0] data_in,
    input  logic       data_valid,
    output logic [9:0] data_out,
    output logic       out_valid,
    output logic       primed
);
    typedef enum logic {FILL, RUN} state_t;
    state_t state;
    logic dv_r, tick, v1, fill_r;
    logic [ADDR_W-1:0] wr_ptr, fill_cnt;
    logic [9:0] x, x_r, rd_data, d, sat;
    logic signed [9:0] dh;
    logic [10:0] sum;
    logic [9:0] mem [2**ADDR_W];
    assign tick = data_valid & ~dv_r;
    assign x = data_in - ADC_OFFSET;
    // Read-before-write: the slot being overwritten holds the sample DELAY ticks old
    always_ff @(posedge sysclk) begin
        if (tick) begin
            rd_data <= mem[wr_ptr];
            mem[wr_ptr] <= x;
        end
    end
    always_comb begin
        d = fill_r ? 10'd0 : rd_data;
        dh = $signed(d) >>> 1;
        sum = {x_r[9], x_r} + {dh[9], dh};
        sat = (sum[10] != sum[9]) ? (sum[10] ? 10'h200 : 10'h1FF) : sum[9:0];
    end
    always_ff @(posedge sysclk) begin
        if (rst) begin
            dv_r <= 1'b1;
            wr_ptr <= '0;
            fill_cnt <= '0;
            state <= FILL;
            primed <= 1'b0;
            v1 <= 1'b0;
            fill_r <= 1'b1;
            x_r <= '0;
            data_out <= DAC_OFFSET;
            out_valid <= 1'b0;
        end else begin
            dv_r <= data_valid;
            v1 <= tick;
            out_valid <= v1;
            if (v1) data_out <= sat + DAC_OFFSET;
            if (tick) begin
                x_r <= x;
                fill_r <= (state == FILL);
                wr_ptr <= (wr_ptr == ADDR_W'(DELAY - 1)) ? '0 : wr_ptr + 1'b1;
                if (state == FILL) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == ADDR_W'(DELAY - 1)) begin
                        state <= RUN;
                        primed <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_echo_restore.sv
// tb_echo_restore: directed tables plus randomized streams against a behavioural comb model,
// and an echo-processor -> echo_restore cascade on a DELAY=8 instance.
module tb_echo_restore;
    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;
    logic rst, data_valid, out_valid, primed;
    logic [9:0] data_in, data_out;
    logic b_rst, b_valid, b_ov, b_primed;
    logic [9:0] b_in, b_out;
    echo_restore #(.DELAY(4), .ADDR_W(2)) dut (
        .sysclk(sysclk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_out(data_out), .out_valid(out_valid), .primed(primed)
    );
    echo_restore #(.DELAY(8), .ADDR_W(3), .ADC_OFFSET(10'h200)) dut8 (
        .sysclk(sysclk), .rst(b_rst), .data_in(b_in), .data_valid(b_valid),
        .data_out(b_out), .out_valid(b_ov), .primed(b_primed)
    );
    typedef struct { logic [9:0] din; logic [9:0] exp; } vec_t;
    int checks = 0, errors = 0;
    int hist[$];
    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask
    // Reference: x = din - 0x181 as a signed number, d = x from DELAY ticks ago (0 before that)
    function automatic logic [9:0] model(input logic [9:0] din);
        logic [9:0] u;
        int x, d, y;
        u = din - 10'h181;
        x = u[9] ? int'(u) - 1024 : int'(u);
        d = (hist.size() >= 4) ? hist[hist.size() - 4] : 0;
        hist.push_back(x);
        y = x + (d >>> 1);
        y = (y > 511) ? 511 : (y < -512) ? -512 : y;
        return 10'(y + 512);
    endfunction
    task automatic do_reset();
        @(negedge sysclk); rst = 1; data_valid = 0;
        @(negedge sysclk);
        @(negedge sysclk); rst = 0;
        hist.delete();
    endtask
    task automatic send(input logic [9:0] din, input logic [9:0] exp, input string nm);
        @(negedge sysclk); data_in = din; data_valid = 1;
        @(negedge sysclk); data_valid = 0;
        check({nm, "_early_ov"}, 10'(out_valid), 10'd0);
        @(negedge sysclk);
        check(nm, data_out, exp);
        check({nm, "_ov"}, 10'(out_valid), 10'd1);
    endtask
    task automatic stream(input int n);
        logic [9:0] prev;
        prev = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge sysclk);
            if (k > 0) begin
                check("stream_out", data_out, prev);
                check("stream_ov", 10'(out_valid), 10'd1);
            end
            data_in = 10'($urandom_range(0, 1023));
            prev = model(data_in);
            data_valid = 1;
            @(negedge sysclk); data_valid = 0;
        end
        @(negedge sysclk);
        check("stream_last", data_out, prev);
    endtask
    initial begin
        vec_t imp[7];
        int cnt, first;
        logic [9:0] fout;
        int yh[$];
        int xv, yd, yv;
        logic [9:0] bexp;
        imp[0] = '{10'h181, 10'h200}; imp[1] = '{10'h1C1, 10'h240};
        imp[2] = '{10'h181, 10'h200}; imp[3] = '{10'h181, 10'h200};
        imp[4] = '{10'h181, 10'h200}; imp[5] = '{10'h181, 10'h220};
        imp[6] = '{10'h181, 10'h200};
        rst = 1; data_valid = 1; data_in = 10'h181;
        b_rst = 1; b_valid = 0; b_in = '0;
        repeat (3) @(negedge sysclk);
        check("reset_out", data_out, 10'h200);
        check("reset_ov", 10'(out_valid), 10'd0);
        check("reset_primed", 10'(primed), 10'd0);
        rst = 0; b_rst = 0; cnt = 0;
        repeat (4) begin @(negedge sysclk); cnt += int'(out_valid); end
        check("release_no_tick", 10'(cnt), 10'd0);
        data_valid = 0;
        for (int i = 0; i < 7; i++) begin
            send(imp[i].din, imp[i].exp, "impulse");
            check("impulse_primed", 10'(primed), 10'(i >= 3));
        end
        // Load the RAM with nonzero samples, then prove FILL masks them after a reset
        do_reset();
        for (int i = 0; i < 4; i++) send(10'h2D6, 10'h355, "load");
        check("load_primed", 10'(primed), 10'd1);
        @(negedge sysclk); data_in = 10'h2D6; data_valid = 1;
        @(negedge sysclk); rst = 1; data_valid = 0;
        @(negedge sysclk);
        check("drop_ov", 10'(out_valid), 10'd0);
        check("drop_out", data_out, 10'h200);
        check("drop_primed", 10'(primed), 10'd0);
        rst = 0;
        @(negedge sysclk);
        check("drop_ov2", 10'(out_valid), 10'd0);
        for (int i = 0; i < 4; i++) begin
            send(10'h181, 10'h200, "fill_mask");
            check("fill_primed", 10'(primed), 10'(i == 3));
        end
        do_reset();
        for (int i = 0; i < 6; i++) send(10'h380, 10'h3FF, "sat_pos");
        do_reset();
        for (int i = 0; i < 6; i++) send(10'h381, 10'h000, "sat_neg");
        do_reset();
        @(negedge sysclk); data_in = 10'h1C1; data_valid = 1;
        cnt = 0; first = -1; fout = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge sysclk);
            if (c == 10) data_valid = 0;
            if (out_valid) begin
                cnt++;
                if (first < 0) begin first = c; fout = data_out; end
            end
        end
        check("strobe_count", 10'(cnt), 10'd1);
        check("strobe_latency", 10'(first), 10'd2);
        check("strobe_out", fout, 10'h240);
        do_reset();
        stream(40);
        // Echo processor y = x - (y[n-8] >>> 1) feeding the DELAY=8 instance must give back x
        for (int k = 0; k < 200; k++) begin
            @(negedge sysclk);
            if (k > 0) begin
                check("cascade_out", b_out, bexp);
                check("cascade_ov", 10'(b_ov), 10'd1);
            end
            xv = int'($urandom_range(0, 400)) - 200;
            yd = (k >= 8) ? yh[k - 8] : 0;
            yv = xv - (yd >>> 1);
            yh.push_back(yv);
            b_in = 10'(yv + 512);
            bexp = 10'(xv + 512);
            b_valid = 1;
            @(negedge sysclk); b_valid = 0;
        end
        @(negedge sysclk);
        check("cascade_last", b_out, bexp);
        check("cascade_primed", 10'(b_primed), 10'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
